hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard controller for the pipelined MIPS core, successor to the fixed load-use hazard unit. It keeps a per-register scoreboard of in-flight writes with variable result latency (ALU, load, multi-cycle multiply) and a write-back slot reservation vector. From these it produces stall and flush controls for PC, IF/ID and ID/EX. It sits beside the decoder in ID; the forwarding unit stays separate and unchanged.

## Interface
- REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W
- MAX_LAT, 4, largest result latency in cycles (≥2)
- LAT_W, $clog2(MAX_LAT+1), latency field width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_reg_write  in  1  instruction writes a register
- id_rd  in  REG_ADDR_W  destination register
- id_lat  in  LAT_W  cycles from issue until result is forwardable (1=ALU, 2=load)
- branch_taken  in  1  branch/jump resolved taken in ID
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_bubble  out  1  replace IF/ID with NOP (flush)
- idex_bubble  out  1  insert NOP into ID/EX
- busy  out  NUM_REGS  register has a pending write (cnt≠0)
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Per register r (r≠0): countdown cnt[r], LAT_W bits. Register 0 is never tracked; busy[0]=0 always.
- Effective latency L = id_lat clamped to 1..MAX_LAT (0→1, >MAX_LAT→MAX_LAT).
- Hazard terms (combinational, from state and inputs):
  - RAW: (id_uses_rs & cnt[id_rs]≥2) | (id_uses_rt & cnt[id_rt]≥2).
  - WAW: id_reg_write & id_rd≠0 & cnt[id_rd]>L.
  - WB conflict: id_reg_write & L<MAX_LAT & sv[L+1]=1.
- stall = id_valid & (RAW | WAW | WBconf).
- issue = id_valid & ~stall.
- Outputs:
  - pc_write = ifid_write = ~stall.
  - idex_bubble = stall | ~id_valid.
  - ifid_bubble = branch_taken & ~stall. A stalled branch never flushes; it flushes on the cycle it proceeds.
- Each edge:
  - every nonzero cnt decrements by 1.
  - sv shifts: sv[k] ← sv[k+1], sv[MAX_LAT] ← 0.
  - on issue with id_reg_write & id_rd≠0: cnt[id_rd] ← L (overrides the decrement) and sv[L] ← 1.
- stall_cnt increments on each stall cycle and saturates at 16'hFFFF.

## Timing
- All outputs are combinational from current state and inputs. There is no added latency.
- Producer issued at edge t with latency L: a dependent consumer in ID stalls for L−1 cycles and issues at edge t+L. ALU (L=1): 0 stalls; load (L=2): 1 stall.
- Simultaneous issue plus decrement on the same register: the issue value wins.
- Simultaneous stall plus branch_taken: stall wins; ifid_bubble=0.
- Reset: while rst_n=0, pc_write=0, ifid_write=0, idex_bubble=1, ifid_bubble=0. At the first edge with rst_n=0, all cnt, sv and stall_cnt clear; busy=0. A reset mid-operation discards all pending entries without waiting.

## Structure
- cpu_pkg holds REG_ADDR_W, the opcode/funct constants shared with Control, and the latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=4.
- One natural sub-module: sb_entry, a single register countdown (load, decrement, busy), generated NUM_REGS−1 times.
- The sv vector and hazard logic live in the top.

## Test plan
- Load r8 (L=2), then add r9=r8+r1 → exactly 1 stall cycle, idex_bubble=1 that cycle, add issues next cycle; stall_cnt=1.
- mul r10 (L=4), then sub r11=r10−r2 → 3 stall cycles; busy[10] falls 4 cycles after mul issue.
- mul r12 (L=4), then addi r12 (L=1) → WAW stall until cnt[12]≤1, i.e. 3 stall cycles.
- Load (L=2) at t, then mul with L=1 to r5 at t+1 → WB conflict stall, 1 cycle.
- beq taken with no hazard → ifid_bubble=1, pc_write=1. beq on a load result → stall 1 cycle with ifid_bubble=0, then ifid_bubble=1.
- Assert rst_n=0 mid-mul with cnt[10]=3 → next edge busy=0, stall_cnt=0, and a dependent instruction issues with no stall after release.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared core constants: register file geometry, decoder opcode/funct codes
// and the result latency of each functional unit class.
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Latency class the decoder presents on id_lat for a given instruction.
    function automatic int unsigned latencyFor(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_LW)
            return LAT_LOAD;
        if (op == OP_RTYPE && (fn == FN_MULT || fn == FN_MULTU))
            return LAT_MUL;
        return LAT_ALU;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: counts down the cycles until a pending register write
// becomes forwardable. A fresh load overrides the running decrement.
module hazard_scoreboard_sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] loadVal,
    output logic [LAT_W-1:0] cnt,
    output logic             busy
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= loadVal;
        else if (cnt != '0)
            cnt <= cnt - LAT_W'(1);
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: per-register write scoreboard plus write-back
// slot reservations, producing PC / IF/ID / ID/EX stall and flush controls.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = hazard_scoreboard_pkg::REG_ADDR_W,
    parameter int MAX_LAT    = LAT_MUL,
    parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs,
    input  logic [REG_ADDR_W-1:0]    id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     id_reg_write,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [LAT_W-1:0]         id_lat,
    input  logic                     branch_taken,
    output logic                     pc_write,
    output logic                     ifid_write,
    output logic                     ifid_bubble,
    output logic                     idex_bubble,
    output logic [2**REG_ADDR_W-1:0] busy,
    output logic [15:0]              stall_cnt
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    function automatic logic [LAT_W-1:0] clampLat(input logic [LAT_W-1:0] lat);
        if (lat == '0)
            return LAT_W'(1);
        if (int'(lat) > MAX_LAT)
            return LAT_W'(MAX_LAT);
        return lat;
    endfunction

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [MAX_LAT:1] svSlot;
    logic [LAT_W-1:0] effLat;
    logic             rawHaz;
    logic             wawHaz;
    logic             wbHaz;
    logic             stall;
    logic             issueWrite;

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : gEntry
        hazard_scoreboard_sb_entry #(
            .LAT_W (LAT_W)
        ) uEntry (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (issueWrite && (id_rd == REG_ADDR_W'(r))),
            .loadVal (effLat),
            .cnt     (cnt[r]),
            .busy    (busy[r])
        );
    end

    assign effLat = clampLat(id_lat);

    // A source is safe once its producer is at most one cycle from forwarding.
    assign rawHaz = (id_uses_rs && (cnt[id_rs] >= LAT_W'(2)))
                 || (id_uses_rt && (cnt[id_rt] >= LAT_W'(2)));

    assign wawHaz = id_reg_write && (id_rd != '0) && (cnt[id_rd] > effLat);

    // svSlot[k] marks a write-back already booked k cycles ahead; after the
    // next shift our own slot would land on what is now index effLat+1.
    always_comb begin
        wbHaz = 1'b0;
        for (int k = 1; k < MAX_LAT; k++) begin
            if (effLat == LAT_W'(k) && svSlot[k+1])
                wbHaz = id_reg_write;
        end
    end

    assign stall      = id_valid && (rawHaz || wawHaz || wbHaz);
    assign issueWrite = id_valid && !stall && id_reg_write && (id_rd != '0);

    assign pc_write    = rst_n && !stall;
    assign ifid_write  = rst_n && !stall;
    assign idex_bubble = !rst_n || stall || !id_valid;
    assign ifid_bubble = rst_n && branch_taken && !stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            svSlot <= '0;
        end else begin
            for (int k = 1; k < MAX_LAT; k++)
                svSlot[k] <= svSlot[k+1] || (issueWrite && effLat == LAT_W'(k));
            svSlot[MAX_LAT] <= issueWrite && (effLat == LAT_W'(MAX_LAT));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed instruction sequences checked against
// a timeline model of pending writes and booked write-back edges.
module tb_hazard_scoreboard;

    localparam int REG_ADDR_W = 5;
    localparam int MAX_LAT    = 4;
    localparam int LAT_W      = 3;
    localparam int NUM_REGS   = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_reg_write;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [LAT_W-1:0]      id_lat;
    logic                  branch_taken;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_bubble;
    logic                  idex_bubble;
    logic [NUM_REGS-1:0]   busy;
    logic [15:0]           stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_LAT    (MAX_LAT),
        .LAT_W      (LAT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_reg_write (id_reg_write),
        .id_rd        (id_rd),
        .id_lat       (id_lat),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_bubble  (ifid_bubble),
        .idex_bubble  (idex_bubble),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a write issued on edge e with latency L is forwardable on edge
    // e+L and occupies the write-back port on that same edge.
    int readyAt [NUM_REGS];
    bit wbBooked [int];
    int curEdge = 0;
    int mStallCnt = 0;

    function automatic int clampL(input int l);
        if (l == 0) return 1;
        if (l > MAX_LAT) return MAX_LAT;
        return l;
    endfunction

    function automatic int remaining(input int r);
        if (r == 0 || readyAt[r] <= curEdge) return 0;
        return readyAt[r] - curEdge;
    endfunction

    initial begin
        int  lat;
        bit  raw, waw, wb, st;
        logic [NUM_REGS-1:0] expBusy;
        for (int r = 0; r < NUM_REGS; r++) readyAt[r] = 0;
        forever begin
            @(negedge clk);
            lat = clampL(int'(id_lat));
            raw = (id_uses_rs && remaining(int'(id_rs)) >= 2)
               || (id_uses_rt && remaining(int'(id_rt)) >= 2);
            waw = id_reg_write && id_rd != 0 && remaining(int'(id_rd)) > lat;
            wb  = id_reg_write && lat < MAX_LAT && wbBooked.exists(curEdge + 1 + lat);
            st  = id_valid && (raw || waw || wb);
            for (int r = 0; r < NUM_REGS; r++) expBusy[r] = (remaining(r) != 0);

            if (!rst_n) begin
                check("m_pc_write",    {31'd0, pc_write},    32'd0);
                check("m_ifid_write",  {31'd0, ifid_write},  32'd0);
                check("m_idex_bubble", {31'd0, idex_bubble}, 32'd1);
                check("m_ifid_bubble", {31'd0, ifid_bubble}, 32'd0);
            end else begin
                check("m_pc_write",    {31'd0, pc_write},    {31'd0, !st});
                check("m_ifid_write",  {31'd0, ifid_write},  {31'd0, !st});
                check("m_idex_bubble", {31'd0, idex_bubble}, {31'd0, st || !id_valid});
                check("m_ifid_bubble", {31'd0, ifid_bubble}, {31'd0, branch_taken && !st});
            end
            check("m_busy",      busy,               expBusy);
            check("m_stall_cnt", {16'd0, stall_cnt}, 32'(mStallCnt));

            curEdge++;
            if (!rst_n) begin
                for (int r = 0; r < NUM_REGS; r++) readyAt[r] = 0;
                wbBooked.delete();
                mStallCnt = 0;
            end else begin
                if (st && mStallCnt < 65535) mStallCnt++;
                if (id_valid && !st && id_reg_write && id_rd != 0) begin
                    readyAt[id_rd] = curEdge + lat;
                    wbBooked[curEdge + lat] = 1'b1;
                end
            end
        end
    end

    task automatic idle(input int n);
        id_valid     = 1'b0;
        id_uses_rs   = 1'b0;
        id_uses_rt   = 1'b0;
        id_reg_write = 1'b0;
        branch_taken = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold one instruction in ID until it issues; report stalls and flushes seen.
    task automatic runInstr(input int rs, input int rt, input bit uRs, input bit uRt,
                            input bit wr, input int rd, input int lat, input bit br,
                            output int stalls, output bit flushStalled, output bit flushGo);
        bit done;
        id_valid     = 1'b1;
        id_rs        = REG_ADDR_W'(rs);
        id_rt        = REG_ADDR_W'(rt);
        id_uses_rs   = uRs;
        id_uses_rt   = uRt;
        id_reg_write = wr;
        id_rd        = REG_ADDR_W'(rd);
        id_lat       = LAT_W'(lat);
        branch_taken = br;
        stalls = 0;
        flushStalled = 1'b0;
        flushGo = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (pc_write) begin
                flushGo = ifid_bubble;
                done = 1'b1;
            end else begin
                stalls++;
                if (ifid_bubble) flushStalled = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: rd=%0d still stalled after 20 cycles", rd);
        end
    endtask

    initial begin
        int s;
        bit fs, fg;
        rst_n        = 1'b0;
        id_valid     = 1'b1;
        id_rs        = '0;
        id_rt        = '0;
        id_uses_rs   = 1'b0;
        id_uses_rt   = 1'b0;
        id_reg_write = 1'b0;
        id_rd        = '0;
        id_lat       = LAT_W'(1);
        branch_taken = 1'b1;

        @(negedge clk);
        check("rst_pc_write",    {31'd0, pc_write},    32'd0);
        check("rst_ifid_write",  {31'd0, ifid_write},  32'd0);
        check("rst_idex_bubble", {31'd0, idex_bubble}, 32'd1);
        check("rst_ifid_bubble", {31'd0, ifid_bubble}, 32'd0);
        check("rst_busy",        busy,                 32'd0);
        check("rst_stall_cnt",   {16'd0, stall_cnt},   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        runInstr(1, 0, 1, 0, 1, 8, 2, 0, s, fs, fg);
        check("load_issue_stalls", s, 0);
        runInstr(8, 1, 1, 1, 1, 9, 1, 0, s, fs, fg);
        check("load_use_stalls", s, 1);
        check("load_use_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        idle(5);

        runInstr(4, 5, 1, 1, 1, 10, 4, 0, s, fs, fg);
        runInstr(10, 2, 1, 1, 1, 11, 1, 0, s, fs, fg);
        check("mul_use_stalls", s, 3);
        check("mul_busy10_clear", {31'd0, busy[10]}, 32'd0);
        check("mul_busy11_set", {31'd0, busy[11]}, 32'd1);
        check("mul_stall_cnt", {16'd0, stall_cnt}, 32'd4);
        idle(5);

        runInstr(4, 5, 1, 1, 1, 12, 4, 0, s, fs, fg);
        runInstr(3, 0, 1, 0, 1, 12, 1, 0, s, fs, fg);
        check("waw_stalls", s, 3);
        check("waw_stall_cnt", {16'd0, stall_cnt}, 32'd7);
        idle(5);

        runInstr(1, 0, 1, 0, 1, 6, 2, 0, s, fs, fg);
        runInstr(2, 3, 1, 1, 1, 5, 1, 0, s, fs, fg);
        check("wb_conflict_stalls", s, 1);
        check("wb_stall_cnt", {16'd0, stall_cnt}, 32'd8);
        idle(5);

        runInstr(1, 2, 1, 1, 0, 0, 1, 1, s, fs, fg);
        check("br_free_stalls", s, 0);
        check("br_free_flush", {31'd0, fg}, 32'd1);
        idle(2);

        runInstr(1, 0, 1, 0, 1, 13, 2, 0, s, fs, fg);
        runInstr(13, 0, 1, 1, 0, 0, 1, 1, s, fs, fg);
        check("br_load_stalls", s, 1);
        check("br_load_flush_in_stall", {31'd0, fs}, 32'd0);
        check("br_load_flush_on_go", {31'd0, fg}, 32'd1);
        check("br_load_stall_cnt", {16'd0, stall_cnt}, 32'd9);
        idle(5);

        runInstr(1, 0, 1, 0, 1, 14, 0, 0, s, fs, fg);
        runInstr(14, 0, 1, 0, 1, 15, 1, 0, s, fs, fg);
        check("lat0_clamp_stalls", s, 0);
        idle(3);
        runInstr(1, 0, 1, 0, 1, 16, 7, 0, s, fs, fg);
        runInstr(16, 0, 1, 0, 1, 17, 1, 0, s, fs, fg);
        check("lat7_clamp_stalls", s, 3);
        check("clamp_stall_cnt", {16'd0, stall_cnt}, 32'd12);
        idle(5);

        runInstr(1, 0, 1, 0, 1, 0, 4, 0, s, fs, fg);
        check("r0_busy", {31'd0, busy[0]}, 32'd0);
        runInstr(0, 0, 1, 1, 1, 18, 1, 0, s, fs, fg);
        check("r0_dep_stalls", s, 0);
        idle(3);

        runInstr(4, 5, 1, 1, 1, 10, 4, 0, s, fs, fg);
        idle(1);
        check("pre_rst_busy10", {31'd0, busy[10]}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_pc_write", {31'd0, pc_write}, 32'd0);
        check("mid_rst_idex_bubble", {31'd0, idex_bubble}, 32'd1);
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;
        runInstr(10, 2, 1, 1, 1, 11, 1, 0, s, fs, fg);
        check("post_rst_dep_stalls", s, 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
